// File: rtl/icache_sa_param.sv
// icache_sa_param: set-associative, read-only instruction cache with
// line fill from a beat-oriented memory port and true-LRU replacement.
//
// Ports
//   clk, reset         single clock, synchronous active-high reset
//   read, i_address    fetch request (held by requester until hit)
//   flush              abort an in-progress line fill
//   invalidate         drop every resident line, abort any fill
//   hit, o_data        combinational hit and fetched word
//   mem_read,
//   mem_address        beat request towards memory
//   mem_valid,
//   mem_data           beat accepted / beat data from memory
//   hit_count,
//   miss_count         saturating statistics
//   o_state            FSM state (00 IDLE, 01 FILL)
module icache_sa_param #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int SETS   = 2,
  parameter int WAYS   = 2,
  parameter int WORDS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              flush,
  input  logic              invalidate,
  output logic              hit,
  output logic [DATA_W-1:0] o_data,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count,
  output logic [1:0]        o_state
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int IDX_S = (IDX_W > 0) ? IDX_W : 1;
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [1:0] {IDLE = 2'b00, FILL = 2'b01} state_t;
  typedef logic [WAYS-1:0][WAY_W-1:0] ages_t;

  state_t            state;
  logic [WAYS-1:0]   valid_q [SETS];
  ages_t             age_q   [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS][WORDS];
  logic [DATA_W-1:0] fill_buf [WORDS];
  logic [TAG_W-1:0]  fill_tag;
  logic [IDX_S-1:0]  fill_idx;
  logic [OFF_W-1:0]  ptr;

  logic [OFF_W-1:0]  req_off;
  logic [IDX_S-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WAYS-1:0]   match;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim;
  logic              any_match;
  logic              start_fill;
  logic              beat;
  logic              install;

  // Age update: ways younger than the touched one grow older by one,
  // the touched way becomes youngest, so ages remain a permutation.
  function automatic ages_t lru_touch(input ages_t ages, input logic [WAY_W-1:0] w);
    ages_t res = ages;
    for (int i = 0; i < WAYS; i++)
      if (ages[i] < ages[w]) res[i] = ages[i] + WAY_W'(1);
    res[w] = '0;
    return res;
  endfunction

  function automatic ages_t lru_init();
    ages_t res;
    for (int i = 0; i < WAYS; i++) res[i] = WAY_W'(i);
    return res;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign req_off = i_address[OFF_W-1:0];
  assign req_idx = IDX_S'((i_address >> OFF_W) & ADDR_W'(SETS - 1));
  assign req_tag = i_address[ADDR_W-1:OFF_W+IDX_W];

  // Lookup stage: tag compare across the indexed set
  always_comb begin
    match   = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      match[w] = valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag);
    for (int w = WAYS - 1; w >= 0; w--)
      if (match[w]) hit_way = WAY_W'(w);
  end

  assign any_match = |match;
  assign hit    = (state == IDLE) && read && any_match && !reset && !invalidate;
  assign o_data = hit ? data_q[req_idx][hit_way][req_off] : '0;

  // Victim: oldest way unless an invalid way exists (lowest index wins)
  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++)
      if (age_q[fill_idx][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[fill_idx][w]) victim = WAY_W'(w);
  end

  assign start_fill = (state == IDLE) && read && !any_match && !reset && !invalidate;
  assign beat       = (state == FILL) && mem_valid && !flush;
  assign install    = beat && (ptr == OFF_W'(WORDS - 1)) && !invalidate && !reset;

  // Control stage: FSM, valid bits, ages, counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mem_read    <= 1'b0;
      mem_address <= '0;
      ptr         <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        age_q[s]   <= lru_init();
      end
    end else if (invalidate) begin
      state    <= IDLE;
      mem_read <= 1'b0;
      ptr      <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        age_q[s]   <= lru_init();
      end
    end else begin
      case (state)
        IDLE: begin
          if (read) begin
            if (any_match) begin
              age_q[req_idx] <= lru_touch(age_q[req_idx], hit_way);
              hit_count      <= sat_inc(hit_count);
            end else begin
              state       <= FILL;
              ptr         <= '0;
              mem_read    <= 1'b1;
              mem_address <= {i_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              miss_count  <= sat_inc(miss_count);
            end
          end
        end
        FILL: begin
          if (flush) begin
            state    <= IDLE;
            mem_read <= 1'b0;
            ptr      <= '0;
          end else if (mem_valid) begin
            ptr         <= ptr + OFF_W'(1);
            mem_address <= mem_address + ADDR_W'(1);
            if (ptr == OFF_W'(WORDS - 1)) begin
              valid_q[fill_idx][victim] <= 1'b1;
              age_q[fill_idx]           <= lru_touch(age_q[fill_idx], victim);
              mem_read                  <= 1'b0;
              state                     <= IDLE;
            end
          end
        end
        default: begin
          state    <= IDLE;
          mem_read <= 1'b0;
        end
      endcase
    end
  end

  // Data stage: fill buffer and tag/data arrays, never reset
  always_ff @(posedge clk) begin
    if (start_fill) begin
      fill_tag <= req_tag;
      fill_idx <= req_idx;
    end
    if (beat) fill_buf[ptr] <= mem_data;
    if (install) begin
      tag_q[fill_idx][victim] <= fill_tag;
      for (int i = 0; i < WORDS; i++)
        data_q[fill_idx][victim][i] <= (i == WORDS - 1) ? mem_data : fill_buf[i];
    end
  end

  assign o_state = state;

endmodule
